// File: rtl/h2f_ram_reader_if.sv
// Avalon-MM read bus toward the command RAM plus the valid/ready word stream toward fabric.
// "master" is the reader side; "slave" is the RAM/sink side.
interface h2f_ram_reader_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic                avm_readdatavalid;
    logic [DATA_W-1:0]   avm_readdata;

    logic                src_valid;
    logic [DATA_W-1:0]   src_data;
    logic                src_last;
    logic                src_ready;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata,
        output src_valid, src_data, src_last,
        input  src_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdatavalid, avm_readdata,
        input  src_valid, src_data, src_last,
        output src_ready
    );
endinterface

// File: rtl/h2f_ram_reader.sv
// Block reader for the HPS-written command RAM: pipelined Avalon-MM reads, credit-limited
// so the small output FIFO can never overflow while the stream sink stalls.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing reads, throttled by outstanding + buffered words
// DRAIN  | every read issued, waiting for the last word to leave the FIFO
// FINISH | one-cycle done pulse, then back to IDLE
module h2f_ram_reader #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    h2f_ram_reader_if.master  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_SUM  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_FILL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] address;
    logic              read_req, read_next;
    logic [ADDR_W:0]   count, count_next;
    logic [ADDR_W:0]   issued, issued_next;
    logic [ADDR_W:0]   popped;
    logic [CNT_W-1:0]  outstanding, outstanding_next;
    logic [CNT_W-1:0]  fifo_count, fifo_count_next;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [CNT_W:0]    credit_sum;

    logic load, accept, push, pop, fifo_valid, head_last;

    assign load       = (state == IDLE) && start && (word_count != '0);
    assign accept     = read_req && !bus.avm_waitrequest;
    // readdatavalid with nothing outstanding belongs to a block abandoned by reset
    assign push       = bus.avm_readdatavalid && (outstanding != '0);
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && bus.src_ready;
    assign head_last  = fifo_valid && ((popped + 1'b1) == count);

    always_comb begin
        count_next  = load ? word_count : count;
        issued_next = issued;
        if (load)
            issued_next = '0;
        else if (accept)
            issued_next = issued + 1'b1;

        outstanding_next = outstanding;
        case ({accept, push})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: outstanding_next = outstanding;
        endcase

        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + 1'b1;
            2'b01:   fifo_count_next = fifo_count - 1'b1;
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        read_next  = 1'b0;
        credit_sum = {1'b0, outstanding_next} + {1'b0, fifo_count_next};

        case (state)
            IDLE: begin
                if (start)
                    state_next = (word_count == '0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (accept && (issued_next == count))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && head_last)
                    state_next = FINISH;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Every in-flight read reserves a FIFO slot, so projected occupancy gates the next request
        if (read_req && bus.avm_waitrequest)
            read_next = 1'b1;
        else if ((state_next == ISSUE) && (issued_next < count_next) && (credit_sum < DEPTH_SUM))
            read_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_req    <= 1'b0;
            address     <= '0;
            count       <= '0;
            issued      <= '0;
            popped      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            read_req    <= read_next;
            count       <= count_next;
            issued      <= issued_next;
            outstanding <= outstanding_next;
            fifo_count  <= fifo_count_next;
            if (load)
                address <= base_addr;
            else if (accept)
                address <= address + 1'b1;
            if (load)
                popped <= '0;
            else if (pop)
                popped <= popped + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= bus.avm_readdata;
        end
    end

    assign bus.avm_address    = address;
    assign bus.avm_read       = read_req;
    assign bus.avm_byteenable = '1;
    assign bus.src_valid      = fifo_valid;
    assign bus.src_data       = mem[rd_ptr];
    assign bus.src_last       = head_last;

    assign busy = (state == ISSUE) || (state == DRAIN);
    assign done = (state == FINISH);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_count == DEPTH_FILL)));

    a_credit: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, outstanding} + {1'b0, fifo_count}) <= DEPTH_SUM);

endmodule

// File: tb/tb_h2f_ram_reader.sv
// Directed bench for h2f_ram_reader with a 1-cycle-latency RAM model and a stream monitor.
`timescale 1ns/1ps
module tb_h2f_ram_reader;
    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy, done;
    logic              waitrequest = 1'b0;
    logic              src_ready = 1'b1;
    logic              rdv = 1'b0;
    logic [DATA_W-1:0] rdata = '0;

    h2f_ram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    h2f_ram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.avm_waitrequest   = waitrequest;
    assign bus.avm_readdatavalid = rdv;
    assign bus.avm_readdata      = rdata;
    assign bus.src_ready         = src_ready;

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        logic [7:0] b;
        b = 8'(a);
        return {16{b}};
    endfunction

    // RAM preloaded with word i = {16{8'(i)}}, one cycle read latency
    always @(posedge clk) begin
        rdv   <= bus.avm_read && !waitrequest;
        rdata <= ram_word(bus.avm_address);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] rx_data[$];
    logic              rx_last[$];
    int                addr_q[$];
    int                acc_cyc[$];
    int                last_pop_cyc = -1;
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.src_valid && src_ready) begin
                rx_data.push_back(bus.src_data);
                rx_last.push_back(bus.src_last);
                if (bus.src_last) last_pop_cyc = cyc;
            end
            if (bus.avm_read && !waitrequest) begin
                addr_q.push_back(int'(bus.avm_address));
                acc_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_block(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        check_val({tag, "_done_seen"}, (dcyc >= 0), 1);
    endtask

    task automatic check_block(input string tag, input int rxb, input int acb,
                               input int b, input int n);
        check_val({tag, "_rx_cnt"}, rx_data.size() - rxb, n);
        check_val({tag, "_rd_cnt"}, addr_q.size() - acb, n);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'((b + i) % 16);
            if (acb + i < addr_q.size())
                check_val($sformatf("%s_addr%0d", tag, i), addr_q[acb + i], a);
            if (rxb + i < rx_data.size()) begin
                check_val($sformatf("%s_data%0d", tag, i), rx_data[rxb + i], ram_word(a));
                check_val($sformatf("%s_last%0d", tag, i), rx_last[rxb + i], (i == n - 1));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},      busy, 0);
        check_val({tag, "_done"},      done, 0);
        check_val({tag, "_avm_read"},  bus.avm_read, 0);
        check_val({tag, "_avm_addr"},  bus.avm_address, 0);
        check_val({tag, "_src_valid"}, bus.src_valid, 0);
        check_val({tag, "_src_last"},  bus.src_last, 0);
        check_val({tag, "_src_data"},  bus.src_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rxb, acb, dcyc, held, dc0;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check_val("byteenable", bus.avm_byteenable, {(DATA_W/8){1'b1}});
        reset = 1'b0;

        // basic read
        rxb = rx_data.size(); acb = addr_q.size();
        start_block(0, 4);
        check_val("basic_busy", busy, 1);
        check_val("basic_read1", bus.avm_read, 1);
        check_val("basic_addr0", bus.avm_address, 0);
        wait_done("basic", dcyc);
        check_block("basic", rxb, acb, 0, 4);
        if (acc_cyc.size() >= acb + 4)
            check_val("basic_b2b", acc_cyc[acb + 3] - acc_cyc[acb], 3);
        check_val("basic_done_lat", dcyc - last_pop_cyc, 1);
        check_val("basic_done_busy", busy, 0);

        // wrap read, started the cycle after done
        rxb = rx_data.size(); acb = addr_q.size();
        start_block(14, 4);
        check_val("wrap_busy", busy, 1);
        wait_done("wrap", dcyc);
        check_block("wrap", rxb, acb, 14, 4);

        // backpressure: credits cap issued reads at FIFO_DEPTH
        rxb = rx_data.size(); acb = addr_q.size();
        src_ready = 1'b0;
        start_block(0, 16);
        repeat (20) @(posedge clk);
        #1;
        check_val("bp_reads", addr_q.size() - acb, 4);
        check_val("bp_read_low", bus.avm_read, 0);
        check_val("bp_valid", bus.src_valid, 1);
        check_val("bp_head", bus.src_data, ram_word(0));
        check_val("bp_last", bus.src_last, 0);
        src_ready = 1'b1;
        wait_done("bp", dcyc);
        check_block("bp", rxb, acb, 0, 16);

        // waitrequest held on the second request
        rxb = rx_data.size(); acb = addr_q.size();
        start_block(0, 4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.avm_read && bus.avm_address == 1) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("wr_found", found, 1);
        waitrequest = 1'b1;
        held = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.avm_read && bus.avm_address == 1) held++;
        end
        waitrequest = 1'b0;
        check_val("wr_hold", held, 4);
        @(posedge clk); #1;
        check_val("wr_next_addr", bus.avm_address, 2);
        wait_done("wr", dcyc);
        check_block("wr", rxb, acb, 0, 4);

        // zero-length block
        acb = addr_q.size();
        start_block(3, 0);
        check_val("zero_done", done, 1);
        check_val("zero_busy", busy, 0);
        check_val("zero_read", bus.avm_read, 0);
        @(posedge clk); #1;
        check_val("zero_done_off", done, 0);
        check_val("zero_reads", addr_q.size() - acb, 0);

        // start while busy is ignored
        rxb = rx_data.size(); acb = addr_q.size(); dc0 = done_cnt;
        start_block(0, 2);
        check_val("ign_busy", busy, 1);
        start = 1'b1; base_addr = 8; word_count = 8;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ign", dcyc);
        repeat (10) @(posedge clk);
        #1;
        check_block("ign", rxb, acb, 0, 2);
        check_val("ign_idle", busy, 0);
        check_val("ign_done_cnt", done_cnt - dc0, 1);

        // reset in the middle of a block
        rxb = rx_data.size();
        start_block(0, 8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (rx_data.size() >= rxb + 2) break;
        end
        check_val("mid_two_words", rx_data.size() - rxb, 2);
        dc0 = done_cnt;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("mid_no_done", done_cnt - dc0, 0);
        check_val("mid_idle_busy", busy, 0);
        check_val("mid_idle_valid", bus.src_valid, 0);
        rxb = rx_data.size(); acb = addr_q.size();
        start_block(5, 2);
        wait_done("post", dcyc);
        check_block("post", rxb, acb, 5, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/h2f_ram_reader.md
Name: h2f_ram_reader

Overview:
- FPGA-side Avalon-MM read master that fetches a block of 128-bit words from the HPS-written 16-word on-chip command RAM.
- The HPS writes the RAM through the slave's s1 port; this block reads it through s2.
- Words are forwarded to fabric logic (for example CNN parameter loaders) on a valid/ready stream.
- Reads are pipelined with a credit limit so the output buffer never overflows under sink backpressure.

Parameters:
- DATA_W, 128, read data / stream width in bits.
- ADDR_W, 4, word address width of the RAM (16 words).
- FIFO_DEPTH, 4, output buffer depth in words; must be a power of 2, at least 2. Also the maximum reads in flight.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a block read; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- word_count  in  ADDR_W+1  number of words to read, 0..16; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the block has completed.
- avm_address  out  ADDR_W  word address.
- avm_read  out  1  read request.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_waitrequest  in  1  slave stall; the request is held while high.
- avm_readdatavalid  in  1  read data valid.
- avm_readdata  in  DATA_W  read data.
- src_valid  out  1  stream word valid.
- src_data  out  DATA_W  stream word.
- src_last  out  1  marks the final word of the block.
- src_ready  in  1  sink accept.

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, src_valid=0, src_last=0, src_data=0. On reset the FIFO, counters and FSM are cleared immediately.
  - Reset mid-block abandons the block with no done pulse.
  - Any readdatavalid arriving after reset is ignored because the outstanding count is 0.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start with word_count=0 goes to FINISH; no bus reads are issued.
  - start with word_count>0 latches base_addr and word_count, sets busy, and goes to ISSUE.
  - start in any other state is ignored.
- ISSUE, credit rule:
  - avm_read is asserted, registered, only when outstanding + fifo_count < FIFO_DEPTH.
  - Therefore the first avm_read appears 1 cycle after start.
- ISSUE, request acceptance:
  - A request is accepted when avm_read=1 and avm_waitrequest=0.
  - While waitrequest is high, address and read are held stable.
  - On acceptance: the address increments modulo 2^ADDR_W (15 wraps to 0), issued count +1, outstanding +1.
  - After the final request is accepted, avm_read drops the next cycle and the FSM goes to DRAIN.
- Outstanding count: increments on an accepted request and decrements on readdatavalid. A simultaneous increment and decrement leaves it unchanged.
- FIFO behaviour:
  - Each readdatavalid pushes avm_readdata into the FIFO. The credit rule guarantees no push when the FIFO is full.
  - The FIFO head drives src_data; src_valid = FIFO not empty.
  - Data is visible on src 1 cycle after its readdatavalid.
  - Push and pop in the same cycle is allowed at any fill level, including full.
- src_last is high when the head word is word number word_count of the block (counted at pop).
- DRAIN: stays until the last word is popped (src_valid & src_ready & src_last), then goes to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then returns to IDLE.
  - A start in the cycle after done is accepted.
- Stream rule: src_data and src_last are held stable while src_valid=1 and src_ready=0.
- Width rules:
  - The issued and popped counters are ADDR_W+1 bits.
  - word_count=16 reads all 16 words, starting at base_addr and wrapping.

Test Plan:
- Basic read: preload the RAM with word i = {16{8'(i)}}, start with base=0, count=4, src_ready=1, no waitrequest -> addresses 0,1,2,3 are issued back to back; src shows words 0..3 with last on word 3; done pulses 1 cycle after that pop.
- Wrap read: base=14, count=4 -> addresses 14,15,0,1; data order matches; src_last is set on the word from address 1.
- Backpressure: count=16, src_ready=0 for 20 cycles -> exactly 4 reads are issued, then avm_read stays 0. Release src_ready -> all 16 words are delivered in order with no loss or duplication.
- Waitrequest: waitrequest high for 3 cycles on the second request -> address 1 is held for 4 cycles with read high; output is unchanged.
- Edge starts:
  - count=0 -> no avm_read; done pulses in the cycle after start.
  - A start asserted during busy is ignored, checked by the issued count.
- Reset mid-op: assert reset after 2 of 8 words are delivered -> all outputs go to their reset values at once, there is no done pulse, and a following start (base=5, count=2) completes normally.
